ccd_pixel_framer: RTL and testbench

//  Sits between ccd_readout/AD9826 and the 4 KiB tx fifo (wclk = clk). Captures the AD9826
//  8-bit bus (MSB then LSB per pixel) and tags each line start and frame end. Buffers these

---
 rtl/ccd_pixel_framer.sv | 171 +++++++++++++++++
 tb/tb_ccd_pixel_framer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ccd_pixel_framer.sv
// rtl/ccd_pixel_framer.sv - AD9826 pixel/line/frame capture into a tagged entry fifo, serialised to a byte stream.
module ccd_pixel_framer #(
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] LINE_HDR  = 8'hC1,
    parameter logic [7:0] FRAME_HDR = 8'hCF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ad_data,
    input  logic        ad_hi_stb,
    input  logic        ad_lo_stb,
    input  logic        line_start,
    input  logic        frame_end,
    input  logic        clear,
    input  logic        tx_wfull,
    output logic [7:0]  tx_wdata,
    output logic        tx_winc,
    output logic        busy,
    output logic        overflow,
    output logic        sync_err,
    output logic [15:0] drop_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_B1, S_B0} state_t;

    logic [17:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count, eff_count;
    logic [17:0]       head, push_entry;
    logic              empty, pop, push, push_req, push_marker, room, drop, proto_err;
    logic [7:0]        msb;
    logic              hi_pend;
    logic [15:0]       line_cnt;
    state_t            state, state_nx;
    logic [15:0]       cur, cur_nx;
    logic [7:0]        wdata_nx;

    assign head    = mem[rd_ptr];
    assign empty   = (count == '0);
    assign tx_winc = (state != S_IDLE) && !tx_wfull;
    assign busy    = !empty || (state != S_IDLE);
    // The serialiser only pulls a new entry when it can start emitting it at once.
    assign pop     = !empty && !tx_wfull && ((state == S_IDLE) || (state == S_B0));

    always_comb begin
        push_req    = 1'b0;
        push_marker = 1'b0;
        push_entry  = '0;
        proto_err   = 1'b0;
        if (frame_end) begin
            push_req    = 1'b1;
            push_marker = 1'b1;
            push_entry  = {2'b10, line_cnt};
            proto_err   = line_start | ad_lo_stb | hi_pend;
        end else if (line_start) begin
            push_req    = 1'b1;
            push_marker = 1'b1;
            push_entry  = {2'b01, line_cnt};
            proto_err   = ad_lo_stb;
        end else if (ad_lo_stb) begin
            if (hi_pend) begin
                push_req   = 1'b1;
                push_entry = {2'b00, msb, ad_data};
            end else begin
                proto_err = 1'b1;
            end
        end
        if (ad_hi_stb && hi_pend)
            proto_err = 1'b1;
    end

    // Room is judged after this cycle's pop; the last slot is kept for markers.
    assign eff_count = count - (ADDR_W+1)'(pop);
    assign room      = push_marker ? (eff_count < DEPTH_C) : (eff_count < PIX_LIMIT);
    assign push      = push_req && room;
    assign drop      = push_req && !room;

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        wdata_nx = tx_wdata;
        case (state)
            S_HDR: if (tx_winc) begin
                state_nx = S_B1;
                wdata_nx = cur[15:8];
            end
            S_B1: if (tx_winc) begin
                state_nx = S_B0;
                wdata_nx = cur[7:0];
            end
            S_B0: if (tx_winc && !pop)
                state_nx = S_IDLE;
            default: ;
        endcase
        if (pop) begin
            cur_nx = head[15:0];
            if (head[17:16] != 2'b00) begin
                state_nx = S_HDR;
                wdata_nx = head[17] ? FRAME_HDR : LINE_HDR;
            end else begin
                state_nx = S_B1;
                wdata_nx = head[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= S_IDLE;
            cur        <= '0;
            tx_wdata   <= '0;
            msb        <= '0;
            hi_pend    <= 1'b0;
            line_cnt   <= '0;
            overflow   <= 1'b0;
            sync_err   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= S_IDLE;
            cur      <= '0;
            tx_wdata <= '0;
            hi_pend  <= 1'b0;
            line_cnt <= '0;
        end else begin
            state    <= state_nx;
            cur      <= cur_nx;
            tx_wdata <= wdata_nx;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);

            if (ad_hi_stb)
                msb <= ad_data;
            if (frame_end)
                hi_pend <= 1'b0;
            else if (ad_hi_stb)
                hi_pend <= 1'b1;
            else if (ad_lo_stb)
                hi_pend <= 1'b0;

            if (frame_end)
                line_cnt <= '0;
            else if (line_start)
                line_cnt <= line_cnt + 1'b1;

            if (proto_err)
                sync_err <= 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ccd_pixel_framer.sv
// tb/tb_ccd_pixel_framer.sv - directed and randomized bench for ccd_pixel_framer against a byte-queue model.
module tb_ccd_pixel_framer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ad_data;
    logic        ad_hi_stb, ad_lo_stb, line_start, frame_end, clear, tx_wfull;
    logic [7:0]  tx_wdata;
    logic        tx_winc, busy, overflow, sync_err;
    logic [15:0] drop_count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] mdl_lines = 0;
    int          mfill, mdrops;
    bit          toggle_full = 0;

    ccd_pixel_framer dut (
        .clk(clk), .rst_n(rst_n), .ad_data(ad_data), .ad_hi_stb(ad_hi_stb),
        .ad_lo_stb(ad_lo_stb), .line_start(line_start), .frame_end(frame_end),
        .clear(clear), .tx_wfull(tx_wfull), .tx_wdata(tx_wdata), .tx_winc(tx_winc),
        .busy(busy), .overflow(overflow), .sync_err(sync_err), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_pix(input logic [7:0] m, input logic [7:0] l);
        exp_q.push_back(m);
        exp_q.push_back(l);
    endtask

    task automatic exp_mark(input logic [7:0] h, input logic [15:0] c);
        exp_q.push_back(h);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
    endtask

    // Inputs are applied at the negedge; outputs are sampled 1 ns later, well before the posedge.
    task automatic cyc();
        logic [8:0] e;
        #1;
        if (tx_winc === 1'b1) begin
            e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            chk("stream_byte", {23'd0, 1'b0, tx_wdata}, {23'd0, e});
        end else begin
            chk("winc_known", {31'd0, tx_winc}, 32'd0);
        end
        @(negedge clk);
        ad_hi_stb = 0; ad_lo_stb = 0; line_start = 0; frame_end = 0; clear = 0;
        if (toggle_full) tx_wfull = ~tx_wfull;
    endtask

    task automatic drain();
        int n = 0;
        toggle_full = 0;
        tx_wfull = 0;
        while ((busy !== 1'b0 || exp_q.size() > 0) && n < 600) begin
            cyc();
            n++;
        end
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("drain_queue_left", exp_q.size(), 32'd0);
    endtask

    task automatic send_pixel(input logic [7:0] m, input logic [7:0] l, input int gap);
        ad_data = m; ad_hi_stb = 1; cyc();
        repeat (gap) cyc();
        ad_data = l; ad_lo_stb = 1; cyc();
    endtask

    initial begin
        logic [7:0] a, b;
        rst_n = 0; ad_data = 0; ad_hi_stb = 0; ad_lo_stb = 0; line_start = 0;
        frame_end = 0; clear = 0; tx_wfull = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;

        chk("rst_winc", {31'd0, tx_winc}, 32'd0);
        chk("rst_wdata", {24'd0, tx_wdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
        chk("rst_drop_count", {16'd0, drop_count}, 32'd0);

        // Single pixel latency.
        ad_data = 8'h12; ad_hi_stb = 1; cyc();
        ad_data = 8'h34; ad_lo_stb = 1; exp_pix(8'h12, 8'h34); cyc();
        chk("lat_n1_winc", {31'd0, tx_winc}, 32'd0);
        cyc();
        chk("lat_n2_winc", {31'd0, tx_winc}, 32'd1);
        chk("lat_n2_data", {24'd0, tx_wdata}, 32'h12);
        cyc();
        chk("lat_n3_winc", {31'd0, tx_winc}, 32'd1);
        chk("lat_n3_data", {24'd0, tx_wdata}, 32'h34);
        cyc();
        chk("lat_n4_busy", {31'd0, busy}, 32'd0);

        // Line markers and frame end.
        for (int i = 0; i < 3; i++) begin
            line_start = 1; exp_mark(8'hC1, mdl_lines); mdl_lines++;
            cyc();
            repeat (3) cyc();
        end
        frame_end = 1; exp_mark(8'hCF, mdl_lines); mdl_lines = 0; cyc();
        drain();
        line_start = 1; exp_mark(8'hC1, mdl_lines); mdl_lines++; cyc();
        drain();

        // Overflow with the output held off.
        tx_wfull = 1; mfill = 0; mdrops = 0;
        for (int i = 0; i < 70; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            ad_data = a; ad_hi_stb = 1; cyc();
            ad_data = b; ad_lo_stb = 1;
            if (mfill < 63) begin exp_pix(a, b); mfill++; end else mdrops++;
            cyc();
        end
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_drops", {16'd0, drop_count}, mdrops);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        frame_end = 1; exp_mark(8'hCF, mdl_lines); mdl_lines = 0; cyc();
        chk("ovf_marker_fits", {16'd0, drop_count}, mdrops);
        drain();

        // Random traffic with the full flag toggling every cycle.
        toggle_full = 1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                line_start = 1; exp_mark(8'hC1, mdl_lines); mdl_lines++; cyc();
            end else begin
                a = 8'($urandom); b = 8'($urandom);
                exp_pix(a, b);
                send_pixel(a, b, $urandom_range(0, 2));
            end
        end
        frame_end = 1; exp_mark(8'hCF, mdl_lines); mdl_lines = 0; cyc();
        drain();
        chk("clean_sync_err", {31'd0, sync_err}, 32'd0);

        // Protocol violations.
        ad_data = 8'h55; ad_lo_stb = 1; cyc();
        chk("lo_no_hi_sync_err", {31'd0, sync_err}, 32'd1);
        ad_data = 8'h66; frame_end = 1; ad_lo_stb = 1;
        exp_mark(8'hCF, mdl_lines); mdl_lines = 0; cyc();
        drain();
        chk("sticky_overflow", {31'd0, overflow}, 32'd1);

        // Clear while the serialiser sits in B1.
        line_start = 1; exp_mark(8'hC1, mdl_lines); mdl_lines++; cyc();
        drain();
        ad_data = 8'hA1; ad_hi_stb = 1; cyc();
        ad_data = 8'hA2; ad_lo_stb = 1; exp_pix(8'hA1, 8'hA2); cyc();
        ad_data = 8'hB1; ad_hi_stb = 1; cyc();
        ad_data = 8'hB2; ad_lo_stb = 1; tx_wfull = 1; cyc();
        chk("clr_pre_busy", {31'd0, busy}, 32'd1);
        clear = 1; cyc();
        exp_q.delete(); mdl_lines = 0; tx_wfull = 0;
        chk("clr_winc", {31'd0, tx_winc}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_wdata", {24'd0, tx_wdata}, 32'd0);
        repeat (3) cyc();
        line_start = 1; exp_mark(8'hC1, mdl_lines); mdl_lines++; cyc();
        drain();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            exp_pix(a, b);
            send_pixel(a, b, 0);
        end
        chk("rstm_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 0; exp_q.delete(); mdl_lines = 0;
        #1;
        chk("rstm_winc", {31'd0, tx_winc}, 32'd0);
        chk("rstm_busy", {31'd0, busy}, 32'd0);
        chk("rstm_drop_count", {16'd0, drop_count}, 32'd0);
        chk("rstm_overflow", {31'd0, overflow}, 32'd0);
        chk("rstm_sync_err", {31'd0, sync_err}, 32'd0);
        repeat (2) cyc();
        rst_n = 1;
        a = 8'($urandom); b = 8'($urandom);
        exp_pix(a, b);
        send_pixel(a, b, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
